// File: rtl/ins_fetch.sv
// Instruction fetch stage: 16 x 16 program memory with a load port, zero-latency
// fetch at pc_in, and the LOAD / RUN / HALT sequencer for the core.
module ins_fetch #(
  parameter int ADDR_W = 4,
  parameter int INS_W  = 16,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [INS_W-1:0]  prog_data,
  input  logic              prog_done,
  input  logic              restart,
  output logic [INS_W-1:0]  INS,
  output logic              ins_valid,
  output logic              set_pc,
  output logic              halted,
  output logic [7:0]        instr_count
);

  typedef enum logic [1:0] {
    LOAD = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  localparam logic [3:0] OP_HALT = 4'hF;

  state_t             state;
  state_t             state_nxt;
  logic [INS_W-1:0]   mem [DEPTH];
  logic [INS_W-1:0]   rd_data;
  logic [3:0]         opcode;

  assign rd_data = mem[pc_in];
  assign opcode  = rd_data[11:8];

  // restart wins over halt detection; the unused encoding falls back to LOAD
  function automatic state_t next_state(input state_t s, input logic done,
                                        input logic rs, input logic [3:0] op);
    case (s)
      LOAD:    return done ? RUN : LOAD;
      RUN:     return rs ? LOAD : ((op == OP_HALT) ? HALT : RUN);
      HALT:    return rs ? LOAD : HALT;
      default: return LOAD;
    endcase
  endfunction

  assign state_nxt = next_state(state, prog_done, restart, opcode);

  // Status flags are registered alongside the state so they mirror it exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      set_pc    <= 1'b1;
      ins_valid <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= state_nxt;
      set_pc    <= (state_nxt != RUN);
      ins_valid <= (state_nxt == RUN);
      halted    <= (state_nxt == HALT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == LOAD && prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Count survives HALT and LOAD so software can read it after a halt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count <= 8'd0;
    end else if (state == LOAD && prog_done) begin
      instr_count <= 8'd0;
    end else if (state == RUN && !restart && instr_count != 8'hFF) begin
      instr_count <= instr_count + 8'd1;
    end
  end

  assign INS = (state == RUN) ? rd_data : '0;

endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch; includes a small model of the downstream pc block
// so that pc_in follows INS / set_pc as it would in the core.
module tb_ins_fetch;

  logic        clk;
  logic        rst_n;
  logic [3:0]  pc_in;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [15:0] prog_data;
  logic        prog_done;
  logic        restart;
  logic [15:0] INS;
  logic        ins_valid;
  logic        set_pc;
  logic        halted;
  logic [7:0]  instr_count;
  logic        alu_eq;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  ins_fetch #(.ADDR_W(4), .INS_W(16), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_done(prog_done), .restart(restart),
    .INS(INS), .ins_valid(ins_valid), .set_pc(set_pc),
    .halted(halted), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pc model: set_pc parks at 0, opcode 4 with alu_eq jumps by signed offset, else +1
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            pc_in <= 4'd0;
    else if (set_pc)                       pc_in <= 4'd0;
    else if (INS[11:8] == 4'h4 && alu_eq)  pc_in <= pc_in + INS[7:4];
    else                                   pc_in <= pc_in + 4'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic done_pulse();
    prog_done = 1'b1;
    tick();
    prog_done = 1'b0;
  endtask

  task automatic restart_pulse();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    prog_done = 1'b0; restart = 1'b0; alu_eq = 1'b0;
    #12;
    chk("rst_set_pc", set_pc, 1);
    chk("rst_ins_valid", ins_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_ins", INS, 16'h0000);
    chk("rst_count", instr_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load increment-only program ending in HALT at address 3
    wr(4'd0, 16'h0300);
    chk("load_set_pc", set_pc, 1);
    chk("load_ins", INS, 16'h0000);
    wr(4'd1, 16'h0300);
    wr(4'd2, 16'h0300);
    wr(4'd3, 16'h0F00);
    chk("load_ins_end", INS, 16'h0000);
    done_pulse();
    chk("run_valid", ins_valid, 1);
    chk("run_pc0", pc_in, 0);
    chk("run_ins0", INS, 16'h0300);
    chk("run_count0", instr_count, 0);
    tick();
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = 16'hFFFF;
    tick();
    prog_we = 1'b0;
    tick();
    chk("halt_op_pc", pc_in, 3);
    chk("halt_op_ins", INS, 16'h0F00);
    chk("halt_op_not_yet", halted, 0);
    tick();
    chk("halt_flag", halted, 1);
    chk("halt_count", instr_count, 4);
    chk("halt_ins_zero", INS, 16'h0000);
    chk("halt_pc_k1", pc_in, 4);
    tick();
    chk("halt_pc_parked", pc_in, 0);
    chk("halt_hold", halted, 1);
    chk("halt_count_hold", instr_count, 4);

    restart_pulse();
    chk("restart_halted", halted, 0);
    chk("restart_set_pc", set_pc, 1);
    chk("restart_valid", ins_valid, 0);
    chk("restart_count_hold", instr_count, 4);

    // Rerun without writes: mem[0] must not hold the RUN-time write
    done_pulse();
    chk("rerun_mem0", INS, 16'h0300);
    chk("rerun_count_clr", instr_count, 0);
    tick(); tick(); tick();
    chk("prio_ins", INS, 16'h0F00);
    restart_pulse();
    chk("prio_not_halted", halted, 0);
    chk("prio_load", set_pc, 1);
    chk("prio_count", instr_count, 3);

    done_pulse();
    tick(); tick(); tick();
    chk("mem3_kept", INS, 16'h0F00);
    tick();
    chk("rerun2_halt", halted, 1);
    chk("rerun2_count", instr_count, 4);
    restart_pulse();

    // Branch passthrough: 0 -> 7 -> 5 (HALT)
    wr(4'd0, 16'h0470);
    wr(4'd7, 16'h04E0);
    wr(4'd5, 16'h0F00);
    alu_eq = 1'b1;
    done_pulse();
    chk("br_pc0", pc_in, 0);
    chk("br_ins0", INS, 16'h0470);
    tick();
    chk("br_pc7", pc_in, 7);
    chk("br_ins7", INS, 16'h04E0);
    tick();
    chk("br_pc5", pc_in, 5);
    chk("br_ins5", INS, 16'h0F00);
    tick();
    chk("br_halted", halted, 1);
    chk("br_count", instr_count, 3);
    restart_pulse();
    alu_eq = 1'b0;

    // Write and done in the same cycle
    prog_we = 1'b1; prog_addr = 4'd2; prog_data = 16'h0F00; prog_done = 1'b1;
    tick();
    prog_we = 1'b0; prog_done = 1'b0;
    chk("wd_run", ins_valid, 1);
    chk("wd_ins0", INS, 16'h0470);
    tick();
    chk("wd_ins1", INS, 16'h0300);
    tick();
    chk("wd_mem2", INS, 16'h0F00);
    tick();
    chk("wd_halted", halted, 1);
    chk("wd_count", instr_count, 3);
    restart_pulse();

    // Asynchronous reset in the middle of RUN
    done_pulse();
    tick();
    chk("ar_count_pre", instr_count, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_set_pc", set_pc, 1);
    chk("ar_valid", ins_valid, 0);
    chk("ar_halted", halted, 0);
    chk("ar_ins", INS, 16'h0000);
    chk("ar_count", instr_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_pulse();
    chk("ar_run", ins_valid, 1);
    chk("ar_mem0_clr", INS, 16'h0000);
    tick();
    chk("ar_mem1_clr", INS, 16'h0000);
    restart_pulse();

    // Saturation over a 300-cycle run
    for (int i = 0; i < 16; i++) wr(i[3:0], 16'h0300);
    done_pulse();
    repeat (254) tick();
    chk("sat_254", instr_count, 254);
    repeat (46) tick();
    chk("sat_255", instr_count, 255);
    chk("sat_still_run", ins_valid, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
